// File: rtl/numbotron_pkg.sv
// Shared numbotron constants: register bank defaults and instruction field layout.
package numbotron_pkg;

    localparam int unsigned NREGS_DEF = 8;
    localparam int unsigned WIDTH_DEF = 8;

    // The instruction word packs three 8-bit register masks. Zero-test is the lowest field.
    localparam int unsigned ZERO_LSB = 0;
    localparam int unsigned DEC_LSB  = 8;
    localparam int unsigned INC_LSB  = 16;
    localparam int unsigned FIELD_W  = 8;
    localparam int unsigned INSTR_W  = 24;

    typedef logic [FIELD_W-1:0] reg_mask_t;

    typedef struct packed {
        reg_mask_t inc;
        reg_mask_t dec;
        reg_mask_t zero;
    } instr_t;

    function automatic reg_mask_t instr_inc(input logic [INSTR_W-1:0] w);
        return w[INC_LSB +: FIELD_W];
    endfunction

    function automatic reg_mask_t instr_dec(input logic [INSTR_W-1:0] w);
        return w[DEC_LSB +: FIELD_W];
    endfunction

    function automatic reg_mask_t instr_zero(input logic [INSTR_W-1:0] w);
        return w[ZERO_LSB +: FIELD_W];
    endfunction

endpackage

// File: rtl/numbotron_bank_arbiter_if.sv
// Thread-to-bank step request bus: per-thread request, inc/dec masks and grant pulse.
interface numbotron_bank_arbiter_if
    import numbotron_pkg::*;
#(
    parameter int unsigned NTHREADS = 4,
    parameter int unsigned NREGS    = NREGS_DEF
) ();

    logic [NTHREADS-1:0]       req;
    logic [NTHREADS*NREGS-1:0] inc_mask;
    logic [NTHREADS*NREGS-1:0] dec_mask;
    logic [NTHREADS-1:0]       gnt;

    modport master (
        output req,
        output inc_mask,
        output dec_mask,
        input  gnt
    );

    modport slave (
        input  req,
        input  inc_mask,
        input  dec_mask,
        output gnt
    );

endinterface

// File: rtl/numbotron_rr_pick.sv
// Combinational round-robin picker: first eligible thread at or after ptr, wrapping.
module numbotron_rr_pick #(
    parameter int unsigned NTHREADS = 4,
    localparam int unsigned PW = (NTHREADS > 1) ? $clog2(NTHREADS) : 1
) (
    input  logic [NTHREADS-1:0] elig,
    input  logic [PW-1:0]       ptr,
    output logic [PW-1:0]       winner,
    output logic                valid
);

    logic [PW:0]   sum;
    logic [PW-1:0] idx;

    // Scan from the farthest offset down so the nearest eligible thread is assigned last.
    always_comb begin
        winner = ptr;
        valid  = |elig;
        sum    = '0;
        idx    = '0;
        for (int i = NTHREADS - 1; i >= 0; i--) begin
            sum = {1'b0, ptr} + (PW+1)'(i);
            if (sum >= (PW+1)'(NTHREADS)) begin
                sum = sum - (PW+1)'(NTHREADS);
            end
            idx = sum[PW-1:0];
            if (elig[idx]) begin
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/numbotron_bank_arbiter.sv
// Shared counter register bank with round-robin step arbitration across numbotron threads.
module numbotron_bank_arbiter
    import numbotron_pkg::*;
#(
    parameter int unsigned NTHREADS = 4,
    parameter int unsigned NREGS    = NREGS_DEF,
    parameter int unsigned WIDTH    = WIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    rstb,
    numbotron_bank_arbiter_if.slave thr,
    input  logic                    cfg_we,
    input  logic [2:0]              cfg_addr,
    input  logic [WIDTH-1:0]        cfg_data,
    output logic [NREGS-1:0]        zero_flags,
    output logic [NREGS*WIDTH-1:0]  reg_values,
    output logic                    ovf_sticky,
    output logic                    udf_sticky
);

    localparam int unsigned PW = $clog2(NTHREADS);

    logic [PW-1:0]                 ptr_q, ptr_d;
    logic [NTHREADS-1:0]           gnt_q, gnt_d;
    logic [NREGS-1:0][WIDTH-1:0]   bank_q, bank_d;
    logic                          ovf_q, ovf_d;
    logic                          udf_q, udf_d;

    logic [NTHREADS-1:0]           elig;
    logic [PW-1:0]                 winner;
    logic                          win_valid;
    logic [NREGS-1:0]              win_inc;
    logic [NREGS-1:0]              win_dec;

    // A thread granted last cycle is still holding the step it just had applied.
    assign elig = thr.req & ~gnt_q;

    numbotron_rr_pick #(
        .NTHREADS (NTHREADS)
    ) u_pick (
        .elig   (elig),
        .ptr    (ptr_q),
        .winner (winner),
        .valid  (win_valid)
    );

    always_comb begin
        win_inc = '0;
        win_dec = '0;
        for (int t = 0; t < NTHREADS; t++) begin
            if (PW'(t) == winner) begin
                win_inc = thr.inc_mask[t*NREGS +: NREGS];
                win_dec = thr.dec_mask[t*NREGS +: NREGS];
            end
        end
    end

    // Next-state: config write beats any step; otherwise apply the winner's masks with saturation.
    always_comb begin
        ptr_d  = ptr_q;
        gnt_d  = '0;
        bank_d = bank_q;
        ovf_d  = ovf_q;
        udf_d  = udf_q;

        if (cfg_we) begin
            if (32'(cfg_addr) < NREGS) begin
                bank_d[cfg_addr] = cfg_data;
            end
        end else if (win_valid) begin
            gnt_d[winner] = 1'b1;
            if (32'(winner) == NTHREADS - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = winner + PW'(1);
            end
            for (int r = 0; r < NREGS; r++) begin
                if (win_inc[r] && !win_dec[r]) begin
                    if (bank_q[r] == {WIDTH{1'b1}}) begin
                        ovf_d = 1'b1;
                    end else begin
                        bank_d[r] = bank_q[r] + WIDTH'(1);
                    end
                end else if (win_dec[r] && !win_inc[r]) begin
                    if (bank_q[r] == '0) begin
                        udf_d = 1'b1;
                    end else begin
                        bank_d[r] = bank_q[r] - WIDTH'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            ptr_q  <= '0;
            gnt_q  <= '0;
            bank_q <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else begin
            ptr_q  <= ptr_d;
            gnt_q  <= gnt_d;
            bank_q <= bank_d;
            ovf_q  <= ovf_d;
            udf_q  <= udf_d;
        end
    end

    always_comb begin
        zero_flags = '0;
        for (int r = 0; r < NREGS; r++) begin
            zero_flags[r] = (bank_q[r] == '0);
        end
    end

    assign reg_values = bank_q;
    assign thr.gnt    = gnt_q;
    assign ovf_sticky = ovf_q;
    assign udf_sticky = udf_q;

endmodule

// File: tb/tb_numbotron_bank_arbiter.sv
// Directed self-checking bench for numbotron_bank_arbiter.
module tb_numbotron_bank_arbiter;

    localparam int unsigned NT = 4;
    localparam int unsigned NR = 8;
    localparam int unsigned W  = 8;

    logic          clk = 1'b0;
    logic          rstb = 1'b0;
    logic          cfg_we;
    logic [2:0]    cfg_addr;
    logic [W-1:0]  cfg_data;
    logic [NR-1:0] zero_flags;
    logic [NR*W-1:0] reg_values;
    logic          ovf_sticky;
    logic          udf_sticky;

    int n_checks = 0;
    int n_fail   = 0;

    numbotron_bank_arbiter_if #(.NTHREADS(NT), .NREGS(NR)) ifc ();

    numbotron_bank_arbiter #(
        .NTHREADS (NT),
        .NREGS    (NR),
        .WIDTH    (W)
    ) dut (
        .clk        (clk),
        .rstb       (rstb),
        .thr        (ifc),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .zero_flags (zero_flags),
        .reg_values (reg_values),
        .ovf_sticky (ovf_sticky),
        .udf_sticky (udf_sticky)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] regv(input int r);
        return reg_values[r*W +: W];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ifc.req      = '0;
        ifc.inc_mask = '0;
        ifc.dec_mask = '0;
        cfg_we       = 1'b0;
        cfg_addr     = '0;
        cfg_data     = '0;
    endtask

    task automatic apply_reset();
        step();
        rstb = 1'b0;
        step();
        rstb = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rstb = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstb = 1'b1;
        repeat (5) step();
        n_checks++;
        if (zero_flags !== 8'hFF) begin n_fail++; $display("FAIL reset_zero_flags: got %h expected ff", zero_flags); end
        n_checks++;
        if (reg_values !== 64'h0) begin n_fail++; $display("FAIL reset_reg_values: got %h expected 0", reg_values); end
        n_checks++;
        if (ifc.gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b expected 0000", ifc.gnt); end
        n_checks++;
        if (ovf_sticky !== 1'b0 || udf_sticky !== 1'b0) begin
            n_fail++; $display("FAIL reset_sticky: got ovf=%b udf=%b expected 0 0", ovf_sticky, udf_sticky);
        end
    endtask

    task automatic test_single_step();
        ifc.req = 4'b0010;
        ifc.inc_mask[1*NR +: NR] = 8'h05;
        step();
        n_checks++;
        if (ifc.gnt !== 4'b0010) begin n_fail++; $display("FAIL single_gnt: got %b expected 0010", ifc.gnt); end
        n_checks++;
        if (regv(0) !== 8'd1 || regv(2) !== 8'd1) begin
            n_fail++; $display("FAIL single_regs: got r0=%0d r2=%0d expected 1 1", regv(0), regv(2));
        end
        n_checks++;
        if (zero_flags !== 8'hFA) begin n_fail++; $display("FAIL single_zero_flags: got %h expected fa", zero_flags); end
        // Request still held in the grant cycle: must not be applied again.
        step();
        n_checks++;
        if (ifc.gnt !== 4'b0000) begin n_fail++; $display("FAIL single_no_regrant: got %b expected 0000", ifc.gnt); end
        n_checks++;
        if (regv(0) !== 8'd1 || zero_flags !== 8'hFA) begin
            n_fail++; $display("FAIL single_no_double_apply: got r0=%0d zf=%h expected 1 fa", regv(0), zero_flags);
        end
        clear_inputs();
        step();
    endtask

    task automatic test_rotation();
        logic [NT-1:0] exp_gnt;
        apply_reset();
        ifc.req      = 4'b1111;
        ifc.inc_mask = {4{8'h01}};
        for (int i = 0; i < 8; i++) begin
            step();
            exp_gnt = NT'(1) << (i % 4);
            n_checks++;
            if (ifc.gnt !== exp_gnt) begin
                n_fail++; $display("FAIL rotation_gnt_%0d: got %b expected %b", i, ifc.gnt, exp_gnt);
            end
        end
        n_checks++;
        if (regv(0) !== 8'd8) begin n_fail++; $display("FAIL rotation_reg0: got %0d expected 8", regv(0)); end
        n_checks++;
        if (zero_flags !== 8'hFE) begin n_fail++; $display("FAIL rotation_zero_flags: got %h expected fe", zero_flags); end
        clear_inputs();
        step();
    endtask

    task automatic test_saturation();
        cfg_we   = 1'b1;
        cfg_addr = 3'd3;
        cfg_data = 8'hFF;
        step();
        cfg_we = 1'b0;
        n_checks++;
        if (regv(3) !== 8'hFF || zero_flags !== 8'hF6) begin
            n_fail++; $display("FAIL cfg_write_reg3: got r3=%h zf=%h expected ff f6", regv(3), zero_flags);
        end
        ifc.req = 4'b0001;
        ifc.inc_mask[0 +: NR] = 8'h08;
        step();
        n_checks++;
        if (ifc.gnt !== 4'b0001) begin n_fail++; $display("FAIL ovf_gnt: got %b expected 0001", ifc.gnt); end
        n_checks++;
        if (regv(3) !== 8'hFF) begin n_fail++; $display("FAIL ovf_saturate: got %h expected ff", regv(3)); end
        n_checks++;
        if (ovf_sticky !== 1'b1 || udf_sticky !== 1'b0) begin
            n_fail++; $display("FAIL ovf_sticky: got ovf=%b udf=%b expected 1 0", ovf_sticky, udf_sticky);
        end
        clear_inputs();
        step();
        ifc.req = 4'b0001;
        ifc.dec_mask[0 +: NR] = 8'h10;
        step();
        n_checks++;
        if (ifc.gnt !== 4'b0001) begin n_fail++; $display("FAIL udf_gnt: got %b expected 0001", ifc.gnt); end
        n_checks++;
        if (regv(4) !== 8'h00 || udf_sticky !== 1'b1) begin
            n_fail++; $display("FAIL udf_sticky: got r4=%h udf=%b expected 00 1", regv(4), udf_sticky);
        end
        n_checks++;
        if (ovf_sticky !== 1'b1) begin n_fail++; $display("FAIL ovf_stays_set: got %b expected 1", ovf_sticky); end
        clear_inputs();
        step();
    endtask

    task automatic test_cfg_priority();
        cfg_we   = 1'b1;
        cfg_addr = 3'd1;
        cfg_data = 8'h07;
        ifc.req  = 4'b0100;
        ifc.inc_mask[2*NR +: NR] = 8'h22;
        ifc.dec_mask[2*NR +: NR] = 8'h02;
        step();
        n_checks++;
        if (ifc.gnt !== 4'b0000) begin n_fail++; $display("FAIL cfg_blocks_gnt: got %b expected 0000", ifc.gnt); end
        n_checks++;
        if (regv(1) !== 8'h07 || regv(5) !== 8'h00) begin
            n_fail++; $display("FAIL cfg_lands: got r1=%h r5=%h expected 07 00", regv(1), regv(5));
        end
        cfg_we = 1'b0;
        step();
        n_checks++;
        if (ifc.gnt !== 4'b0100) begin n_fail++; $display("FAIL deferred_gnt: got %b expected 0100", ifc.gnt); end
        n_checks++;
        if (regv(1) !== 8'h07 || regv(5) !== 8'h01) begin
            n_fail++; $display("FAIL inc_dec_cancel: got r1=%h r5=%h expected 07 01", regv(1), regv(5));
        end
        clear_inputs();
        step();
    endtask

    task automatic test_async_reset();
        ifc.req = 4'b0010;
        ifc.inc_mask[1*NR +: NR] = 8'h01;
        step();
        n_checks++;
        if (ifc.gnt !== 4'b0010 || regv(0) !== 8'd9) begin
            n_fail++; $display("FAIL pre_reset_state: got gnt=%b r0=%0d expected 0010 9", ifc.gnt, regv(0));
        end
        #2;
        rstb = 1'b0;
        #1;
        n_checks++;
        if (zero_flags !== 8'hFF || reg_values !== 64'h0) begin
            n_fail++; $display("FAIL async_reset_bank: got zf=%h regs=%h expected ff 0", zero_flags, reg_values);
        end
        n_checks++;
        if (ifc.gnt !== 4'b0000 || ovf_sticky !== 1'b0 || udf_sticky !== 1'b0) begin
            n_fail++; $display("FAIL async_reset_ctrl: got gnt=%b ovf=%b udf=%b expected 0000 0 0", ifc.gnt, ovf_sticky, udf_sticky);
        end
        ifc.req      = 4'b1111;
        ifc.inc_mask = {4{8'h01}};
        step();
        step();
        n_checks++;
        if (ifc.gnt !== 4'b0000 || reg_values !== 64'h0) begin
            n_fail++; $display("FAIL reset_hold: got gnt=%b regs=%h expected 0000 0", ifc.gnt, reg_values);
        end
        rstb = 1'b1;
        step();
        n_checks++;
        if (ifc.gnt !== 4'b0001 || regv(0) !== 8'd1) begin
            n_fail++; $display("FAIL restart_thread0: got gnt=%b r0=%0d expected 0001 1", ifc.gnt, regv(0));
        end
        clear_inputs();
        step();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single_step();
        test_rotation();
        test_saturation();
        test_cfg_priority();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/numbotron_bank_arbiter.md
Name: numbotron_bank_arbiter

Overview:
Owns the shared counter register bank and arbitrates step requests from NTHREADS numbotron threads.
- Each thread presents inc/dec register masks from its current instruction.
- The arbiter picks one thread per cycle, round-robin, and applies that thread's masks atomically.
- It returns per-register zero flags that every thread uses for zero tests.
- A config write port loads register values while editing.

Parameters:
NTHREADS, 4, number of requesting threads (2..8)
NREGS, 8, number of counter registers; matches the 8-bit mask fields of an instruction
WIDTH, 8, bit width of each counter register

Ports:
clk  in  1  system clock
rstb  in  1  asynchronous active-low reset
req  in  NTHREADS  per-thread step request; held until gnt
inc_mask  in  NTHREADS*NREGS  per-thread increment mask; thread t uses bits [t*NREGS +: NREGS]
dec_mask  in  NTHREADS*NREGS  per-thread decrement mask; same packing as inc_mask
gnt  out  NTHREADS  one-cycle pulse: that thread's step was applied on the previous edge
cfg_we  in  1  config write strobe
cfg_addr  in  3  config register index
cfg_data  in  WIDTH  config write value
zero_flags  out  NREGS  bit r = 1 when register r == 0
reg_values  out  NREGS*WIDTH  flat register contents, for display
ovf_sticky  out  1  an increment saturated since the last reset
udf_sticky  out  1  a decrement hit zero since the last reset

Behaviour:
- Reset (rstb low, asynchronous):
  - all registers = 0, so zero_flags = all 1s
  - gnt = 0, ovf_sticky = 0, udf_sticky = 0
  - round-robin pointer = thread 0 has highest priority
  - all state is held while rstb is low; operation resumes on the first clk edge after release.
- Eligibility, evaluated each cycle: elig[t] = req[t] & ~gnt[t]. A thread granted last cycle cannot win this cycle, so the same step can never be applied twice.
- cfg_we has absolute priority:
  - on that edge, register cfg_addr = cfg_data; cfg_addr >= NREGS is ignored
  - no thread is granted and gnt = 0 next cycle
  - the pointer is unchanged.
- Otherwise, if any elig bit is set:
  - the winner is the first eligible thread at or after the pointer, wrapping modulo NTHREADS
  - on the edge: apply the winner's masks, set gnt to one-hot(winner) for one cycle, and set pointer = winner+1 mod NTHREADS.
- No eligible requester: bank unchanged, gnt = 0, pointer unchanged.
- Per-register update for the winner:
  - inc=1, dec=0: value+1, saturating at 2^WIDTH-1; saturation sets ovf_sticky
  - inc=0, dec=1: value-1, saturating at 0; dec at 0 sets udf_sticky
  - inc=1, dec=1: no change, flags unaffected
  - inc=0, dec=0: no change
- Latency:
  - zero_flags and reg_values are driven combinationally from the register flops.
  - They reflect the update in the same cycle gnt is high.
- Requester rules:
  - The thread keeps req and its masks stable until it sees gnt.
  - In the gnt cycle it may drop req or present new masks.
  - A thread that drops req before gnt has no effect on the bank.
- Throughput: one step per cycle bank-wide; at most one step every 2 cycles per thread.
- Sticky flags clear only on reset.
- Simultaneous events:
  - cfg write and requests in the same cycle: cfg wins and requests wait.
  - All threads requesting: strict rotation 0,1,2,3,0,... with no starvation.

Decomposition:
- numbotron_pkg holds:
  - NREGS and WIDTH defaults
  - instruction field positions: ZERO_LSB=0, DEC_LSB=8, INC_LSB=16, FIELD_W=8
  - the instruction word width
- Sub-module numbotron_rr_pick:
  - parameterised NTHREADS
  - inputs elig and pointer; outputs winner index and a valid bit
  - purely combinational
- The top level holds the pointer, the register bank, the saturating update logic and the sticky flags.

Test Plan:
- Reset then idle 5 cycles -> zero_flags=8'hFF, reg_values all 0, gnt=0, sticky flags 0.
- Thread 1 req with inc_mask=8'h05, held until gnt -> one gnt[1] pulse; reg0=1, reg2=1, zero_flags=8'hFA; thread 1 keeps req high one more cycle with the same masks -> no second apply that cycle.
- Threads 0-3 all req continuously with inc_mask=8'h01 -> gnt order 0,1,2,3,0,...; after 8 cycles reg0=8.
- cfg write reg 3 = 8'hFF, then inc reg3 -> reg3 stays 255 and ovf_sticky=1; dec_mask=8'h10 with reg4=0 -> reg4 stays 0 and udf_sticky=1.
- cfg_we high while thread 2 is requesting -> the cfg write lands and gnt=0; the next cycle gnt[2] with its masks applied; inc_mask=dec_mask=8'h02 -> reg1 unchanged.
- Deassert rstb mid-stream with reg values nonzero -> all outputs return to reset values immediately, without waiting for a clock edge; arbitration restarts at thread 0.
